// File: rtl/matrix_mult_seq.sv
// Sequencer for a 5x5 signed matrix product C = A x B. Latches A and B on start, presents one
// (row of A, column of B) pair per cycle to an external inner-product stage with a 1-cycle
// registered latency, and stores each returned element and overflow flag into C.
module matrix_mult_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N*N*W-1:0]   i_mat_a,
  input  logic [N*N*W-1:0]   i_mat_b,
  output logic [N*W-1:0]     o_lin,
  output logic [N*W-1:0]     o_col,
  input  logic [W-1:0]       i_n_out,
  input  logic               i_ovf,
  output logic [N*N*W-1:0]   o_mat_c,
  output logic [N*N-1:0]     o_ovf_map,
  output logic               o_ovf_any,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IW = $clog2(N * N);
  localparam int RW = $clog2(N);
  localparam logic [IW-1:0] LastIdx = IW'(N * N - 1);
  localparam logic [RW-1:0] LastCol = RW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e         r_state;
  logic [W-1:0]   r_a [N][N];
  logic [W-1:0]   r_b [N][N];
  logic [W-1:0]   r_c [N*N];
  logic [N*N-1:0] r_ovf_map;
  logic           r_ovf_any;
  logic           r_busy;
  logic           r_done;
  logic [IW-1:0]  r_idx;
  logic [RW-1:0]  r_i;
  logic [RW-1:0]  r_j;
  logic           r_cap_vld;
  logic [IW-1:0]  r_cap_idx;

  // Row/column presented to the inner-product stage come straight from the latched copies, so
  // they hold their last value through DRAIN and after completion.
  for (genvar gk = 0; gk < N; gk++) begin : g_vec
    assign o_lin[gk*W +: W] = r_a[r_i][gk];
    assign o_col[gk*W +: W] = r_b[gk][r_j];
  end

  for (genvar gm = 0; gm < N * N; gm++) begin : g_c
    assign o_mat_c[gm*W +: W] = r_c[gm];
  end

  assign o_ovf_map = r_ovf_map;
  assign o_ovf_any = r_ovf_any;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

  // Control FSM, issue counters, operand latches and result capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_ovf_map <= '0;
      r_ovf_any <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      for (int ii = 0; ii < N; ii++) begin
        for (int jj = 0; jj < N; jj++) begin
          r_a[ii][jj] <= '0;
          r_b[ii][jj] <= '0;
        end
      end
      for (int mm = 0; mm < N * N; mm++) r_c[mm] <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cap_vld <= 1'b0;

      // Result for the element issued last cycle is on n_out/ovf now.
      if (r_cap_vld) begin
        r_c[r_cap_idx]       <= i_n_out;
        r_ovf_map[r_cap_idx] <= i_ovf;
        r_ovf_any            <= r_ovf_any | i_ovf;
      end

      case (r_state)
        StIdle: begin
          r_busy <= 1'b0;
          // The done cycle blocks a held-high start from retriggering on the very next edge.
          if (i_start && !r_done) begin
            for (int ii = 0; ii < N; ii++) begin
              for (int jj = 0; jj < N; jj++) begin
                r_a[ii][jj] <= i_mat_a[(ii*N+jj)*W +: W];
                r_b[ii][jj] <= i_mat_b[(ii*N+jj)*W +: W];
              end
            end
            for (int mm = 0; mm < N * N; mm++) r_c[mm] <= '0;
            r_ovf_map <= '0;
            r_ovf_any <= 1'b0;
            r_idx     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_state   <= StRun;
          end
        end
        StRun: begin
          r_busy    <= 1'b1;
          r_cap_vld <= 1'b1;
          r_cap_idx <= r_idx;
          if (r_idx == LastIdx) begin
            r_state <= StDrain;
          end else begin
            r_idx <= r_idx + IW'(1);
            if (r_j == LastCol) begin
              r_j <= '0;
              r_i <= r_i + RW'(1);
            end else begin
              r_j <= r_j + RW'(1);
            end
          end
        end
        StDrain: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
